// File: rtl/mdu_pkg.sv
// ============================================================================
// Module : mdu_pkg
// Shared operation codes, FSM states and counter sizing for mdu_iter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_iter.sv
// ============================================================================
// Module : mdu_iter
// Iterative multiply/divide unit: one bit per cycle over a shared accumulator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_iter
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [OP_WIDTH-1:0]   op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] c_last   = CNT_W'(DATA_WIDTH - 1);
  localparam logic [W-1:0]     c_minneg = {1'b1, {(W-1){1'b0}}};

  state_e           r_state;
  op_e              r_op;
  logic             r_neg;
  logic [CNT_W-1:0] r_cnt;
  logic [2*W-1:0]   r_acc;
  logic [W-1:0]     r_opb;
  logic [W-1:0]     r_result;

  // request decode
  op_e          w_op;
  logic         w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [W-1:0] w_a_mag, w_b_mag;
  logic         w_div_zero, w_ovf, w_short, w_neg;
  logic [W-1:0] w_short_res;

  assign w_op       = op_e'(op_i[2:0]);
  assign w_is_div   = op_i[2];
  assign w_a_sgn    = w_is_div ? ~op_i[0] : (w_op != OP_MULHU);
  assign w_b_sgn    = w_is_div ? ~op_i[0] : (w_op == OP_MUL || w_op == OP_MULH);
  assign w_a_neg    = w_a_sgn & a_i[W-1];
  assign w_b_neg    = w_b_sgn & b_i[W-1];
  assign w_a_mag    = w_a_neg ? -a_i : a_i;
  assign w_b_mag    = w_b_neg ? -b_i : b_i;
  assign w_div_zero = w_is_div && (b_i == '0);
  assign w_ovf      = w_is_div && !op_i[0] && (a_i == c_minneg) && (b_i == '1);
  assign w_short    = w_div_zero || w_ovf;
  // REM follows the dividend sign; everything else takes the xor of both signs
  assign w_neg      = (w_is_div && op_i[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

  always_comb begin
    w_short_res = '0;
    if (w_div_zero)
      w_short_res = op_i[1] ? a_i : '1;
    else
      w_short_res = op_i[1] ? '0 : a_i;
  end

  // one iteration step for each path
  logic [W:0]     w_msum, w_trial;
  logic           w_qbit;
  logic [W-1:0]   w_rem;
  logic [2*W-1:0] w_acc_nxt, w_prod;
  logic [W-1:0]   w_quo_s, w_rem_s, w_final;

  assign w_msum    = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_acc[0] ? r_opb : '0)};
  assign w_trial   = r_acc[2*W-1:W-1] - {1'b0, r_opb};
  assign w_qbit    = ~w_trial[W];
  assign w_rem     = w_qbit ? w_trial[W-1:0] : r_acc[2*W-2:W-1];
  assign w_acc_nxt = r_op[2] ? {w_rem, r_acc[W-2:0], w_qbit}
                             : {w_msum, r_acc[W-1:1]};

  assign w_prod  = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_quo_s = r_neg ? -w_acc_nxt[W-1:0] : w_acc_nxt[W-1:0];
  assign w_rem_s = r_neg ? -w_acc_nxt[2*W-1:W] : w_acc_nxt[2*W-1:W];

  always_comb begin
    w_final = '0;
    if (r_op[2])
      w_final = r_op[1] ? w_rem_s : w_quo_s;
    else
      w_final = (r_op == OP_MUL) ? w_prod[W-1:0] : w_prod[2*W-1:W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= OP_MUL;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_result <= '0;
    end else if (flush_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_op  <= w_op;
            r_neg <= w_neg;
            r_cnt <= '0;
            if (w_short) begin
              r_result <= w_short_res;
              r_state  <= S_DONE;
            end else begin
              // divide: {remainder, dividend}; multiply: {product hi, multiplier}
              r_acc   <= {{W{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
              r_opb   <= w_is_div ? w_b_mag : w_a_mag;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == c_last) begin
            r_result <= w_final;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (ready_i)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o  = (r_state == S_IDLE);
  assign valid_o  = (r_state == S_DONE);
  assign result_o = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter.sv
// ============================================================================
// Module : tb_mdu_iter
// Self-checking bench for mdu_iter against an arithmetic reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mdu_iter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b1;
  logic [2:0]    op_i = 3'd0;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic          ready_o;
  logic          valid_o;
  logic [W-1:0]  result_o;

  int checks = 0;
  int errors = 0;

  mdu_iter #(.DATA_WIDTH(W), .OP_WIDTH(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (flush_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_short(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // one full transaction with ready_i high; latency counted from the accepting edge
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          n;
    int          exp_lat;
    logic [31:0] exp;
    exp     = ref_mdu(op, a, b);
    exp_lat = is_short(op, a, b) ? 0 : W;
    @(negedge clk);
    check({tag, " ready"}, 32'(ready_o), 32'd1);
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b; ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
    n = 0;
    while (valid_o !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " result"}, result_o, exp);
    @(posedge clk); #1;
    check({tag, " idle"}, {30'b0, valid_o, ready_o}, 32'd1);
  endtask

  initial begin
    int          n;
    int          seen;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    #12;
    check("reset ready", 32'(ready_o), 32'd1);
    check("reset valid", 32'(valid_o), 32'd0);
    check("reset result", result_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("mul 7*-3",     3'd0, 32'd7, 32'hFFFF_FFFD);
    check("mul 7*-3 const", ref_mdu(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    run_op("mulhu",        3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulh",         3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu",       3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div -7/2",     3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op("rem -7/2",     3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op("divu 100/7",   3'd5, 32'd100, 32'd7);
    run_op("remu 100/7",   3'd7, 32'd100, 32'd7);
    run_op("div 5/0",      3'd4, 32'd5, 32'd0);
    run_op("remu 5/0",     3'd7, 32'd5, 32'd0);
    run_op("div ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
    end

    // result held in DONE while the consumer stalls
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd5; a_i = 32'd100; b_i = 32'd7; ready_i = 1'b0;
    @(posedge clk); #1;
    valid_i = 1'b0;
    n = 0;
    while (valid_o !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold latency", 32'(n), 32'd32);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      valid_i = 1'b1; op_i = 3'd0; a_i = $urandom; b_i = $urandom;
      @(posedge clk); #1;
      check("hold valid", 32'(valid_o), 32'd1);
      check("hold result", result_o, 32'd14);
      check("hold ready", 32'(ready_o), 32'd0);
    end
    @(negedge clk); valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk); #1;
    check("hold release", {30'b0, valid_o, ready_o}, 32'd1);
    @(posedge clk); #1;
    check("no accept on release", 32'(ready_o), 32'd1);

    // flush at iteration 10
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd0; a_i = 32'd123; b_i = 32'd456;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush idle", {30'b0, valid_o, ready_o}, 32'd1);

    // reset mid-CALC of the next op
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd4; a_i = 32'd1000; b_i = 32'd3;
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("calc busy", 32'(ready_o), 32'd0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset idle", {30'b0, valid_o, ready_o}, 32'd1);
    check("async reset result", result_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid_o !== 1'b0 || ready_o !== 1'b1) seen++;
    end
    check("no stale result", 32'(seen), 32'd0);

    run_op("post reset div", 3'd4, 32'hFFFF_FC18, 32'd3);
    run_op("post reset mul", 3'd0, 32'd123, 32'd456);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (even, >= 8).
- REQ-002 SHALL have parameter OP_WIDTH, default 3, width of the operation code.
- REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
- REQ-005 SHALL have port flush_i, input, 1, synchronous abort of any in-flight operation.
- REQ-006 SHALL have port valid_i, input, 1, request valid.
- REQ-007 SHALL have port ready_o, output, 1, unit can accept a request.
- REQ-008 SHALL have port op_i, input, OP_WIDTH, operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- REQ-009 SHALL have port a_i, input, DATA_WIDTH, operand A (dividend or multiplicand).
- REQ-010 SHALL have port b_i, input, DATA_WIDTH, operand B (divisor or multiplier).
- REQ-011 SHALL have port valid_o, output, 1, result valid.
- REQ-012 SHALL have port ready_i, input, 1, consumer accepts the result.
- REQ-013 SHALL have port result_o, output, DATA_WIDTH, registered result.

Function
- REQ-014 SHALL implement FSM states IDLE, CALC and DONE, with ready_o = (state == IDLE) and valid_o = (state == DONE).
- REQ-015 SHALL accept a request on a rising edge with valid_i && ready_o, latching op_i, operand magnitudes and result-sign flags.
- REQ-016 SHALL treat MUL/MULH/DIV/REM operands as signed, MULHSU A as signed and B as unsigned, and MULHU/DIVU/REMU operands as unsigned.
- REQ-017 SHALL run multiplication as unsigned shift-add over a 2*DATA_WIDTH accumulator, one bit per cycle, negating the product when its sign flag is set; MUL returns the low half and MULH* the high half.
- REQ-018 SHALL run division as unsigned restoring division, one quotient bit per cycle, with the quotient negated if operand signs differ (DIV) and the remainder taking the dividend sign (REM).
- REQ-019 SHALL, in CALC, perform exactly DATA_WIDTH iterations and enter DONE on the edge completing the last one, so valid_o rises exactly DATA_WIDTH rising edges after the accepting edge.
- REQ-020 SHALL, when divisor = 0, go directly to DONE at the accepting edge: DIV/DIVU all ones, REM/REMU = a_i.
- REQ-021 SHALL, for signed overflow (DIV/REM with a_i = most-negative and b_i = -1), go directly to DONE: DIV = a_i, REM = 0.
- REQ-022 SHALL, for the short-circuit cases, assert valid_o one rising edge after acceptance.
- REQ-023 SHALL hold result_o and valid_o stable in DONE while ready_i = 0.
- REQ-024 SHALL return from DONE to IDLE on an edge with ready_i = 1, with no new request accepted on that same edge (back-to-back throughput one op per DATA_WIDTH+2 cycles minimum).
- REQ-025 SHALL ignore valid_i while not IDLE; op_i, a_i and b_i need not be held after acceptance.
- REQ-026 SHALL, on flush_i = 1 at a rising edge, go to IDLE from any state, discard the in-flight result and accept nothing on that edge; flush_i has priority over all other inputs.
- REQ-027 SHALL keep result_o at its last value outside DONE; result_o is don't-care when valid_o = 0.

Reset
- REQ-028 SHALL, while rst_n = 0, asynchronously force the FSM to IDLE, the iteration counter to 0, result_o to 0 and the accumulators to 0.
- REQ-029 SHALL hold ready_o = 1 and valid_o = 0 during reset.
- REQ-030 SHALL discard an operation interrupted by reset mid-CALC without producing a result.
- REQ-031 SHALL release reset synchronously to clk at system level; the block itself needs no synchronizer.

Structure
- REQ-032 SHALL define the operation enum, the FSM state enum and the iteration counter width ($clog2(DATA_WIDTH+1)) in shared package mdu_pkg.
- REQ-033 SHALL be a single module with no sub-module, the multiply and divide paths sharing one accumulator/counter datapath.

Verification
- REQ-034 SHALL cover: MUL a = 7, b = -3 -> result 0xFFFFFFEB, valid_o exactly 32 edges after accept.
- REQ-035 SHALL cover: MULHU a = b = 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a = -1, b = 0xFFFFFFFF -> 0xFFFFFFFF.
- REQ-036 SHALL cover: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- REQ-037 SHALL cover: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM -> 0; each with valid_o one edge after accept.
- REQ-038 SHALL cover: ready_i held 0 for 5 cycles in DONE -> result_o and valid_o stable, ready_o = 0, new valid_i ignored.
- REQ-039 SHALL cover: flush_i at iteration 10, then rst_n asserted mid-CALC of the next op -> IDLE, no valid_o, following request completes correctly.
